// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and encodings for the write-back register file
package wb_regfile_pkg;

    localparam int          DW        = 32;
    localparam int          AW        = 5;
    localparam int          NREG      = 2 ** AW;
    localparam int          REG_ZERO  = 0;
    localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back / register-read bundle between pipeline and register file
interface wb_regfile_if #(
    parameter int DW = wb_regfile_pkg::DW,
    parameter int AW = wb_regfile_pkg::AW
);

    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] mD;
    logic [DW-1:0] mC;
    logic [AW-1:0] wrn;
    logic [31:0]   winstr;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] wdata;
    logic [31:0]   retired;

    modport master (
        output wwreg, wm2reg, mD, mC, wrn, winstr, rs_a, rs_b,
        input  qa, qb, wdata, retired
    );

    modport slave (
        input  wwreg, wm2reg, mD, mC, wrn, winstr, rs_a, rs_b,
        output qa, qb, wdata, retired
    );

endinterface

// File: rtl/wb_regfile_core.sv
// rtl/wb_regfile_core.sv - register array, one write port and two asynchronous read ports
module regfile_core #(
    parameter int DW = wb_regfile_pkg::DW,
    parameter int AW = wb_regfile_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b
);
    import wb_regfile_pkg::*;

    localparam int N = 2 ** AW;

    logic [DW-1:0] regs [N];

    // Entry 0 is cleared by reset and never selected for write, so it reads 0 forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back mux, write-through bypass and retired-instruction counter
module wb_regfile #(
    parameter int DW = wb_regfile_pkg::DW,
    parameter int AW = wb_regfile_pkg::AW
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    import wb_regfile_pkg::*;

    logic          we;
    logic          byp_a;
    logic          byp_b;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic [31:0]   retired_q;

    assign wd = bus.wm2reg ? bus.mD : bus.mC;
    assign we = bus.wwreg && (bus.wrn != AW'(REG_ZERO));

    // Bypass is gated by rst_n so reads stay 0 while the array is held clear.
    assign byp_a = rst_n && we && (bus.rs_a == bus.wrn);
    assign byp_b = rst_n && we && (bus.rs_b == bus.wrn);

    regfile_core #(
        .DW (DW),
        .AW (AW)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (bus.wrn),
        .wdata (wd),
        .ra_a  (bus.rs_a),
        .ra_b  (bus.rs_b),
        .rd_a  (rd_a),
        .rd_b  (rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (bus.winstr != INSTR_NOP) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.qa      = byp_a ? wd : rd_a;
    assign bus.qb      = byp_b ? wd : rd_b;
    assign bus.wdata   = wd;
    assign bus.retired = retired_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DW, 32, datapath width in bits.
REQ-002 Parameter AW, 5, register-address width (2**AW registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wwreg  input  1  write-back enable from the MEM/WB register.
REQ-006 wm2reg  input  1  select: 1 = memory data, 0 = ALU result.
REQ-007 mD  input  DW  memory load data from the MEM/WB register.
REQ-008 mC  input  DW  ALU result from the MEM/WB register.
REQ-009 wrn  input  AW  destination register number.
REQ-010 winstr  input  32  instruction in WB; 0 = bubble.
REQ-011 rs_a  input  AW  read-port A address (ID stage).
REQ-012 rs_b  input  AW  read-port B address (ID stage).
REQ-013 qa  output  DW  read-port A data.
REQ-014 qb  output  DW  read-port B data.
REQ-015 wdata  output  DW  selected write-back value (to forwarding network).
REQ-016 retired  output  32  count of non-bubble instructions completed.

Function
REQ-017 wdata SHALL be combinational: wm2reg ? mD : mC.
REQ-018 Write SHALL occur at the rising clk edge iff rst_n=1, wwreg=1 and wrn!=0: reg[wrn] <= wdata.
REQ-019 Register 0 SHALL never be written and SHALL always read 0.
REQ-020 qa/qb SHALL be combinational, zero-latency reads of the register array.
REQ-021 Write-through bypass: if wwreg=1, wrn!=0 and rs_x==wrn, qx SHALL equal wdata in the same cycle.
REQ-022 Both ports reading the same address SHALL return identical values, bypass included.
REQ-023 retired SHALL increment by 1 at each rising edge where winstr!=0, independent of wwreg.
REQ-024 retired SHALL wrap from 32'hFFFF_FFFF to 0 with no flag or stall.
REQ-025 wwreg=1 with wrn=0 SHALL neither modify state nor activate bypass; qa/qb for address 0 stay 0.
REQ-026 X on mD/mC SHALL NOT propagate to the array when wwreg=0.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all registers 1..2**AW-1 and retired to 0.
REQ-028 While rst_n=0, writes and counter increments SHALL be suppressed; qa/qb SHALL read 0 for every address except via the REQ-021 bypass, which SHALL be gated off during reset.
REQ-029 Reset asserted mid-write SHALL discard the write; the first write SHALL occur at the first rising edge with rst_n=1.

Structure
REQ-030 A shared package SHALL hold DW, AW, NREG=2**AW, REG_ZERO=0 and the bubble encoding INSTR_NOP=32'h0.
REQ-031 Storage SHALL be a sub-module regfile_core (one write port, two async read ports); the mux, bypass and counter SHALL live in wb_regfile.
REQ-032 No latches; array reset SHALL be a per-register async clear.

Verification
REQ-033 Reset, then wwreg=1, wm2reg=0, mC=32'h1234_5678, wrn=5, rs_a=5 -> qa=32'h1234_5678 in that cycle (bypass); after the edge, with wwreg=0, qa is still 32'h1234_5678.
REQ-034 wwreg=1, wm2reg=1, mD=32'hDEAD_BEEF, mC=32'h1, wrn=31 -> wdata=32'hDEAD_BEEF; reg31=32'hDEAD_BEEF after the edge.
REQ-035 wwreg=1, wrn=0, mC=32'hFFFF_FFFF, rs_a=rs_b=0 -> qa=qb=0 before and after the edge.
REQ-036 Force retired to 32'hFFFF_FFFE, drive winstr=32'h2002_0001 for 2 cycles then 0 for 1 cycle -> sequence FFFF_FFFF, 0000_0000, 0000_0000.
REQ-037 Write reg7=32'hA5A5_A5A5; pulse rst_n low mid-cycle with wwreg=1, wrn=7, mC=32'h1 -> reg7=0 and retired=0 immediately; after release reg7 stays 0 until the next enabled edge.
REQ-038 Random 10k-cycle run against a reference array model -> qa/qb/wdata/retired match every cycle.
